// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic int unsigned frame_ticks(input int unsigned dbit,
                                                input int unsigned os_tick,
                                                input int unsigned sb_tick,
                                                input bit          parity);
        return os_tick * (1 + dbit + (parity ? 1 : 0)) + sb_tick;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Synchronous FIFO for the UART transmitter; head entry is visible
// combinationally so the FSM can pop and load in the same cycle.
module uart_tx_fifo_mem #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wr_data,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Pointers carry one extra wrap bit, so their difference is the occupancy.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == PW'(DEPTH));
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO plus LSB-first serialiser with back-to-back frames.
// Define UART_TX_PARITY_EN to add the parity_mode port and the PARITY state.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned OS_TICK    = 16,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_tick,
    input  logic                          wr_en,
    input  logic [DBIT-1:0]               wr_data,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]                    parity_mode,
`endif
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow_tick,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done_tick
);

    localparam int unsigned TMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
    localparam int unsigned TW   = $clog2(TMAX);
    localparam int unsigned BW   = $clog2(DBIT);

    localparam logic [TW-1:0] OS_LAST  = TW'(OS_TICK - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

    tx_state_t       state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic [1:0]      par_mode_q, par_mode_d;
    logic            par_acc_q, par_acc_d;
`endif

    logic            pop;
    logic            push;
    logic            empty;
    logic [DBIT-1:0] head;

    assign push          = wr_en & (~full | pop);
    assign overflow_tick = wr_en & full & ~pop;

    uart_tx_fifo_mem #(
        .DW    (DBIT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_mode_q <= PAR_NONE;
            par_acc_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_mode_q <= par_mode_d;
            par_acc_q  <= par_acc_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_mode_d = par_mode_q;
        par_acc_d  = par_acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                pop = ~empty;
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
                        par_acc_d = par_acc_q ^ shift_q[0];
`endif
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = STOP;
`ifdef UART_TX_PARITY_EN
                            if (par_mode_q == PAR_EVEN || par_mode_q == PAR_ODD) begin
                                state_d = PARITY;
                            end
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tick_q == SB_LAST) begin
                        tick_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                        pop     = ~empty;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Loading is shared by IDLE and the back-to-back exit from STOP.
        if (pop) begin
            shift_d = head;
            tick_d  = '0;
            bit_d   = '0;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_mode_d = parity_mode;
            par_acc_d  = 1'b0;
`endif
        end
    end

    // Decoded from the next state so the registered line changes on the transition edge.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_acc_d ^ (par_mode_q == PAR_ODD);
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames,
// a line monitor decodes tx and compares against the queue head.
module tb_uart_tx_fifo;

    typedef struct {
        logic [8:0]  data;
        int unsigned dbit;
        bit          par;
        logic        pbit;
        int unsigned sb;
        int unsigned len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    bit         tick_en = 1'b1;
    bit         sel = 1'b0;

    logic       wr_en1 = 1'b0;
    logic [7:0] wr_data1 = '0;
    logic       full1, ovf1, tx1, busy1, done1;
    logic [2:0] count1;

    logic       wr_en2 = 1'b0;
    logic [4:0] wr_data2 = '0;
    logic       full2, ovf2, tx2, busy2, done2;
    logic [2:0] count2;

`ifdef UART_TX_PARITY_EN
    logic [1:0] parity_mode = 2'b00;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          in_frame = 1'b0;
    bit          spurious = 1'b0;
    int unsigned ticks = 0;
    int unsigned done_cnt = 0;
    logic [8:0]  got;

    logic m_tx, m_done;
    assign m_tx   = sel ? tx2 : tx1;
    assign m_done = sel ? done2 : done1;

    uart_tx_fifo #(
        .DBIT(8), .OS_TICK(16), .SB_TICK(16), .FIFO_DEPTH(4)
    ) dut1 (
        .clk(clk), .reset(rst_n), .s_tick(s_tick), .wr_en(wr_en1), .wr_data(wr_data1),
`ifdef UART_TX_PARITY_EN
        .parity_mode(parity_mode),
`endif
        .full(full1), .fifo_count(count1), .overflow_tick(ovf1),
        .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
    );

    uart_tx_fifo #(
        .DBIT(5), .OS_TICK(16), .SB_TICK(32), .FIFO_DEPTH(4)
    ) dut2 (
        .clk(clk), .reset(rst_n), .s_tick(s_tick), .wr_en(wr_en2), .wr_data(wr_data2),
`ifdef UART_TX_PARITY_EN
        .parity_mode(parity_mode),
`endif
        .full(full2), .fifo_count(count2), .overflow_tick(ovf2),
        .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2)
    );

    initial forever #5 clk = ~clk;

    // One tick every 4 clocks, driven just after the rising edge.
    initial begin
        int unsigned div = 0;
        forever begin
            @(posedge clk);
            #1;
            s_tick = tick_en && (div == 3);
            div = (div + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input logic [8:0] data, input int unsigned dbit, input bit par,
                                input logic pbit, input int unsigned sb, input int unsigned len);
        exp_t e;
        e.data = data; e.dbit = dbit; e.par = par; e.pbit = pbit; e.sb = sb; e.len = len;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        int unsigned nb;
        int unsigned idx;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                continue;
            end
            if (m_done) begin
                done_cnt++;
                check("done_in_frame", in_frame, 1);
                if (in_frame && !spurious) check("frame_len", ticks, cur.len);
                in_frame = 1'b0;
            end
            if (!in_frame && !m_tx) begin
                in_frame = 1'b1;
                ticks = 0;
                got = '0;
                check("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    spurious = 1'b0;
                    cur = exp_q.pop_front();
                end else begin
                    spurious = 1'b1;
                    cur.dbit = sel ? 5 : 8; cur.par = 1'b0; cur.sb = sel ? 32 : 16;
                    cur.len = sel ? 128 : 160;
                end
            end
            if (in_frame && s_tick) begin
                ticks++;
                nb = 1 + cur.dbit + (cur.par ? 1 : 0);
                if (!spurious) begin
                    if (ticks % 16 == 8 && ticks / 16 < nb) begin
                        idx = ticks / 16;
                        if (idx == 0) begin
                            check("start_bit", m_tx, 0);
                        end else if (idx <= cur.dbit) begin
                            got[idx-1] = m_tx;
                            if (idx == cur.dbit) check("data", got, cur.data);
                        end else begin
                            check("parity_bit", m_tx, cur.pbit);
                        end
                    end
                    if (ticks == nb * 16 + cur.sb / 2) check("stop_bit", m_tx, 1);
                end
                if (ticks > cur.len + 2) begin
                    check("frame_timeout", ticks, cur.len);
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic wait_drain(input int unsigned budget);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", (exp_q.size() == 0 && !in_frame), 1);
        exp_q.delete();
        in_frame = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_ticks(input int unsigned n);
        int unsigned c = 0;
        while (c < n) begin
            @(negedge clk);
            if (s_tick) c++;
        end
    endtask

    initial begin : stimulus
        logic [7:0] ovf_bytes [6];
        int unsigned d0;
        int unsigned drops;
        int unsigned n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", tx1, 1);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_ovf", ovf1, 0);
        check("rst_full", full1, 0);
        check("rst_count", count1, 0);
        check("rst_dut2", {tx2, busy2, done2, ovf2, full2, count2}, 8'b1000_0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame 0x55 and push-to-start latency
        @(posedge clk); #1;
        wr_en1 = 1'b1; wr_data1 = 8'h55;
        expect_frame(9'h055, 8, 1'b0, 1'b0, 16, 160);
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        @(negedge clk);
        check("lat_count_after_push", count1, 1);
        check("lat_tx_still_idle", tx1, 1);
        @(negedge clk);
        check("lat_tx_start", tx1, 0);
        check("lat_busy", busy1, 1);
        check("lat_count_after_pop", count1, 0);
        wait_drain(4000);
        check("single_busy_end", busy1, 0);

        // Back-to-back 0x41 0x42 0x43
        d0 = done_cnt;
        @(posedge clk); #1;
        wr_en1 = 1'b1; wr_data1 = 8'h41;
        expect_frame(9'h041, 8, 1'b0, 1'b0, 16, 160);
        @(posedge clk); #1;
        wr_data1 = 8'h42;
        expect_frame(9'h042, 8, 1'b0, 1'b0, 16, 160);
        @(negedge clk);
        check("b2b_count_1", count1, 1);
        @(posedge clk); #1;
        wr_data1 = 8'h43;
        expect_frame(9'h043, 8, 1'b0, 1'b0, 16, 160);
        @(negedge clk);
        check("b2b_count_2", count1, 1);
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        @(negedge clk);
        check("b2b_count_3", count1, 2);
        drops = 0;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 8000) begin
            @(negedge clk);
            #1;
            n++;
            if ((exp_q.size() != 0 || in_frame) && !busy1) drops++;
        end
        check("b2b_busy_gaps", drops, 0);
        check("b2b_done_pulses", done_cnt - d0, 3);
        check("b2b_count_end", count1, 0);
        wait_drain(100);

        // Overflow with the serialiser stalled
        ovf_bytes[0] = 8'h11; ovf_bytes[1] = 8'h22; ovf_bytes[2] = 8'h33;
        ovf_bytes[3] = 8'h44; ovf_bytes[4] = 8'h55; ovf_bytes[5] = 8'h66;
        tick_en = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            wr_en1 = 1'b1; wr_data1 = ovf_bytes[i];
            if (i < 5) expect_frame({1'b0, ovf_bytes[i]}, 8, 1'b0, 1'b0, 16, 160);
            @(negedge clk);
            check("ovf_tick", ovf1, (i == 5) ? 1 : 0);
            if (i == 4) check("ovf_not_full_yet", full1, 0);
            if (i == 5) check("ovf_full", full1, 1);
        end
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        @(negedge clk);
        check("ovf_count_held", count1, 4);
        check("ovf_tick_clear", ovf1, 0);
        tick_en = 1'b1;
        wait_drain(8000);

`ifdef UART_TX_PARITY_EN
        // Even then odd parity; mode change mid-frame must not affect frame 1
        parity_mode = 2'b01;
        @(posedge clk); #1;
        wr_en1 = 1'b1; wr_data1 = 8'h07;
        expect_frame(9'h007, 8, 1'b1, 1'b1, 16, 176);
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        repeat (3) @(negedge clk);
        parity_mode = 2'b10;
        @(posedge clk); #1;
        wr_en1 = 1'b1; wr_data1 = 8'h07;
        expect_frame(9'h007, 8, 1'b1, 1'b0, 16, 176);
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        wait_drain(6000);
        parity_mode = 2'b00;
`endif

        // Reset during DATA bit 3 of 0xC3, with 0x3C still queued
        @(posedge clk); #1;
        wr_en1 = 1'b1; wr_data1 = 8'hC3;
        expect_frame(9'h0C3, 8, 1'b0, 1'b0, 16, 160);
        @(posedge clk); #1;
        wr_data1 = 8'h3C;
        expect_frame(9'h03C, 8, 1'b0, 1'b0, 16, 160);
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        wait_ticks(72);
        check("pre_rst_tx_bit3", tx1, 0);
        check("pre_rst_count", count1, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_tx", tx1, 1);
        check("midrst_count", count1, 0);
        check("midrst_busy", busy1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        wr_en1 = 1'b1; wr_data1 = 8'hA5;
        expect_frame(9'h0A5, 8, 1'b0, 1'b0, 16, 160);
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        wait_drain(4000);

        // Geometry: DBIT=5, SB_TICK=32
        sel = 1'b1;
        @(posedge clk); #1;
        wr_en2 = 1'b1; wr_data2 = 5'h1F;
        expect_frame(9'h01F, 5, 1'b0, 1'b0, 32, 128);
        @(posedge clk); #1;
        wr_en2 = 1'b0;
        wait_drain(4000);
        check("geom_busy_end", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
